oddr_tx_sequencer: RTL and testbench

Burst sequencer that feeds a Gowin ODDR primitive from a valid/ready word stream. It serializes each DATA_W-bit word into DATA_W/2 bit pairs on D0/D1, one pair per clock. It also generates the ODDR tristate control TX, with a programmable lead-in before each burst and a programmable hold-off after it. It sits between a packet source and the ODDR of a bidirectional DDR pin.

---
 rtl/oddr_ctl_pkg.sv | 18 +
 rtl/oddr_tx_sequencer.sv | 131 +++++++++++++
 tb/tb_oddr_tx_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/oddr_ctl_pkg.sv
// Shared state encoding, counter width and beat helper for the ODDR transmit sequencer.
package oddr_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TRAIL = 2'd3
  } oddr_state_e;

  localparam int unsigned CNT_W = 4;

  // Bit pairs needed to send one word
  function automatic int unsigned BEATS(input int unsigned data_w);
    return data_w / 2;
  endfunction

endpackage

// File: rtl/oddr_tx_sequencer.sv
// Serializes a valid/ready word stream into D0/D1 bit pairs for a Gowin ODDR and
// drives its TX tristate with programmable lead-in and hold-off around each burst.
module oddr_tx_sequencer
  import oddr_ctl_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LEAD_CYC  = 1,
  parameter int unsigned TRAIL_CYC = 1,
  parameter logic        IDLE_VAL  = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] S_DATA,
  input  logic              S_VALID,
  input  logic              S_LAST,
  output logic              S_READY,
  output logic              D0,
  output logic              D1,
  output logic              TX,
  output logic              BUSY,
  output logic              UNDERRUN
);

  localparam int unsigned BEATS_N = BEATS(DATA_W);
  localparam int unsigned BEAT_W  = (BEATS_N > 1) ? $clog2(BEATS_N) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_N - 1);

  if ((DATA_W % 2) != 0 || DATA_W < 2 || DATA_W > 64 || LEAD_CYC > 15 || TRAIL_CYC > 15)
  begin : g_bad_param
    $error("oddr_tx_sequencer: DATA_W must be even 2..64, LEAD_CYC/TRAIL_CYC <= 15");
  end

  oddr_state_e       state;
  logic [DATA_W-1:0] sr;
  logic              last_q;
  logic [BEAT_W-1:0] beat;
  logic [CNT_W-1:0]  cnt;
  logic              final_beat;
  logic              accept;

  assign final_beat = (state == ST_SHIFT) && (beat == LAST_BEAT);
  assign S_READY    = !RESET && ((state == ST_IDLE) || (final_beat && !last_q));
  assign accept     = S_VALID && S_READY;

  // The registered pair always shows the beat belonging to the state being entered
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      sr       <= '0;
      last_q   <= 1'b0;
      beat     <= '0;
      cnt      <= '0;
      D0       <= IDLE_VAL;
      D1       <= IDLE_VAL;
      TX       <= 1'b1;
      BUSY     <= 1'b0;
      UNDERRUN <= 1'b0;
    end else begin
      UNDERRUN <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            last_q <= S_LAST;
            TX     <= 1'b0;
            BUSY   <= 1'b1;
            if (LEAD_CYC == 0) begin
              state <= ST_SHIFT;
              D0    <= S_DATA[0];
              D1    <= S_DATA[1];
              sr    <= S_DATA >> 2;
              beat  <= '0;
            end else begin
              state <= ST_LEAD;
              sr    <= S_DATA;
              cnt   <= CNT_W'(LEAD_CYC - 1);
            end
          end
        end
        ST_LEAD: begin
          if (cnt == '0) begin
            state <= ST_SHIFT;
            D0    <= sr[0];
            D1    <= sr[1];
            sr    <= sr >> 2;
            beat  <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (!final_beat) begin
            D0   <= sr[0];
            D1   <= sr[1];
            sr   <= sr >> 2;
            beat <= beat + BEAT_W'(1);
          end else if (accept) begin
            // Back-to-back word: first pair follows with no gap
            D0     <= S_DATA[0];
            D1     <= S_DATA[1];
            sr     <= S_DATA >> 2;
            beat   <= '0;
            last_q <= S_LAST;
          end else begin
            D0       <= IDLE_VAL;
            D1       <= IDLE_VAL;
            UNDERRUN <= !last_q;
            if (TRAIL_CYC == 0) begin
              state <= ST_IDLE;
              TX    <= 1'b1;
              BUSY  <= 1'b0;
            end else begin
              state <= ST_TRAIL;
              cnt   <= CNT_W'(TRAIL_CYC - 1);
            end
          end
        end
        ST_TRAIL: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            TX    <= 1'b1;
            BUSY  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oddr_tx_sequencer.sv
// Bench for oddr_tx_sequencer: two instances (lead/trail 1 and 0), burst table with
// per-cycle expected outputs queued at accept, plus reset and backpressure sequences.
module tb_oddr_tx_sequencer;

  localparam int unsigned NB = 4;

  typedef struct packed {
    logic tx;
    logic d0;
    logic d1;
    logic busy;
    logic und;
  } obs_t;

  typedef struct {
    bit         sel;     // 0: lead/trail 1, 1: lead/trail 0
    int         n;       // words in burst (1 or 2)
    logic [7:0] w0;
    logic [7:0] w1;
    bit         proper;  // final word carries S_LAST
    bit         hold;    // keep S_VALID high after the last word
  } burst_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_last;
  logic       v_a, v_b;
  logic       r_a, r_b;
  logic       d0_a, d1_a, tx_a, busy_a, und_a;
  logic       d0_b, d1_b, tx_b, busy_b, und_b;

  int checks      = 0;
  int failures    = 0;
  int accepts     = 0;
  int exp_accepts = 0;
  obs_t sb[$];
  burst_t tbl[9];

  always #5 clk = ~clk;

  oddr_tx_sequencer #(.DATA_W(8), .LEAD_CYC(1), .TRAIL_CYC(1), .IDLE_VAL(1'b0)) dut_a (
    .CLK(clk), .RESET(rst), .S_DATA(s_data), .S_VALID(v_a), .S_LAST(s_last),
    .S_READY(r_a), .D0(d0_a), .D1(d1_a), .TX(tx_a), .BUSY(busy_a), .UNDERRUN(und_a)
  );

  oddr_tx_sequencer #(.DATA_W(8), .LEAD_CYC(0), .TRAIL_CYC(0), .IDLE_VAL(1'b0)) dut_b (
    .CLK(clk), .RESET(rst), .S_DATA(s_data), .S_VALID(v_b), .S_LAST(s_last),
    .S_READY(r_b), .D0(d0_b), .D1(d1_b), .TX(tx_b), .BUSY(busy_b), .UNDERRUN(und_b)
  );

  function automatic obs_t observe(input bit sel);
    return sel ? {tx_b, d0_b, d1_b, busy_b, und_b} : {tx_a, d0_a, d1_a, busy_a, und_a};
  endfunction

  function automatic logic handshake(input bit sel);
    return sel ? (v_b && r_b) : (v_a && r_a);
  endfunction

  task automatic set_valid(input bit sel, input logic val);
    if (sel) v_b = val;
    else     v_a = val;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshake is sampled at the falling edge, where inputs and S_READY are settled
  task automatic wait_accept(input bit sel, output bit ok);
    bit hs;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      hs = handshake(sel);
      @(posedge clk);
      #1;
      if (hs) ok = 1'b1;
    end
  endtask

  task automatic run_burst(input burst_t b, input string tag);
    int   lead, trail, n_acc;
    bit   ok, hs;
    obs_t e, a;
    logic [7:0] w;
    lead  = b.sel ? 0 : 1;
    trail = lead;
    s_data = b.w0;
    s_last = (b.n == 1) && b.proper;
    set_valid(b.sel, 1'b1);
    exp_accepts += b.n;
    wait_accept(b.sel, ok);
    check({tag, " accept"}, 32'(ok), 32'd1);
    if (!ok) begin
      set_valid(b.sel, 1'b0);
      return;
    end
    accepts++;
    for (int j = 0; j < lead; j++) sb.push_back(5'b00010);
    for (int k = 0; k < b.n * NB; k++) begin
      w = (k / NB == 0) ? b.w0 : b.w1;
      sb.push_back({1'b0, w[2*(k%NB)], w[2*(k%NB)+1], 1'b1, 1'b0});
    end
    for (int r = 1; r <= trail; r++) sb.push_back({4'b0001, (r == 1) && !b.proper});
    sb.push_back({4'b1000, (trail == 0) && !b.proper});
    if (b.n > 1) begin
      s_data = b.w1;
      s_last = b.proper;
    end else if (b.hold) begin
      s_data = 8'hFF;
      s_last = 1'b1;
    end else begin
      set_valid(b.sel, 1'b0);
    end
    n_acc = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      a = observe(b.sel);
      check($sformatf("%s cyc%0d", tag, n_acc * 100 + sb.size()), 32'(a), 32'(e));
      if (sb.size() == 0) set_valid(b.sel, 1'b0);
      hs = handshake(b.sel);
      @(posedge clk);
      #1;
      if (hs) begin
        n_acc++;
        accepts++;
        if (b.hold) begin
          s_data = 8'hFF;
          s_last = 1'b1;
        end else begin
          set_valid(b.sel, 1'b0);
        end
      end
    end
    check({tag, " extra_accepts"}, 32'(n_acc), 32'(b.n - 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    tbl[0] = '{1'b0, 1, 8'hB4, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 2, 8'h0F, 8'hF0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1, 8'hA5, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 2, 8'h3C, 8'h81, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1, 8'h5A, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1, 8'hB4, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 2, 8'h0F, 8'hF0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1, 8'h69, 8'h00, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1, 8'hE7, 8'h00, 1'b1, 1'b1};

    // Reset with S_VALID asserted: nothing may be accepted
    rst = 1'b1;
    s_data = 8'hAA;
    s_last = 1'b1;
    v_a = 1'b1;
    v_b = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("reset ready_a", 32'(r_a), 32'd0);
      check("reset ready_b", 32'(r_b), 32'd0);
    end
    check("reset outputs_a", 32'(observe(1'b0)), 32'(5'b10000));
    check("reset outputs_b", 32'(observe(1'b1)), 32'(5'b10000));
    v_a = 1'b0;
    v_b = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) run_burst(tbl[i], $sformatf("burst%0d", i));

    // Reset during the third pair drops the word without an underrun
    s_data = 8'h96;
    s_last = 1'b1;
    set_valid(1'b0, 1'b1);
    exp_accepts++;
    wait_accept(1'b0, ok);
    check("rst_mid accept", 32'(ok), 32'd1);
    if (ok) accepts++;
    set_valid(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid beat2", 32'(observe(1'b0)), 32'(5'b01010));
    rst = 1'b1;
    #1;
    check("rst_mid ready", 32'(r_a), 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid outputs", 32'(observe(1'b0)), 32'(5'b10000));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid stays_idle", 32'(observe(1'b0)), 32'(5'b10000));
    run_burst(tbl[0], "post_reset");

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    check("accept count", 32'(accepts), 32'(exp_accepts));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
